ether_arp_rx: RTL and testbench

GMII receive-side ARP parser and the counterpart of the sample ARP transmitter. It runs on the 125 MHz PHY receive clock. It strips the preamble and SFD, checks the FCS, and checks the Ethernet and ARP header fields. For each valid ARP request or reply aimed at this station, it presents the sender MAC/IP and opcode with a one-cycle strobe. Downstream, an ARP responder and cache consume these outputs.

---
 rtl/ether_pkg.sv | 45 ++++
 rtl/crc.sv | 46 ++++
 rtl/ether_arp_rx.sv | 240 ++++++++++++++++++++++++
 tb/tb_ether_arp_rx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ether_pkg.sv
// Shared Ethernet/ARP constants, receive byte offsets and the RX state type.
package ether_pkg;

    localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IP  = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
    localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
    localparam logic [7:0]  ARP_HLEN_ETH  = 8'h06;
    localparam logic [7:0]  ARP_PLEN_IP   = 8'h04;

    localparam logic [7:0]  PREAMBLE      = 8'h55;
    localparam logic [7:0]  SFD           = 8'hD5;

    // Number of trailing FCS bytes held back from the CRC.
    localparam int          FCS_BYTES     = 4;

    // Byte offsets counted from the first byte after the SFD.
    localparam logic [11:0] OFF_DST       = 12'd0;
    localparam logic [11:0] OFF_TYPE      = 12'd12;
    localparam logic [11:0] OFF_HTYPE     = 12'd14;
    localparam logic [11:0] OFF_PTYPE     = 12'd16;
    localparam logic [11:0] OFF_HLEN      = 12'd18;
    localparam logic [11:0] OFF_PLEN      = 12'd19;
    localparam logic [11:0] OFF_OP        = 12'd20;
    localparam logic [11:0] OFF_SHA       = 12'd22;
    localparam logic [11:0] OFF_SPA       = 12'd28;
    localparam logic [11:0] OFF_TPA       = 12'd38;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_BODY,
        ST_CHECK,
        ST_DROP
    } rx_state_t;

    // True when byte offset 'off' lies inside the field [start, start+len).
    function automatic logic in_field(input logic [11:0] off,
                                      input logic [11:0] start,
                                      input logic [11:0] len);
        return (off >= start) && (off < start + len);
    endfunction

endpackage

// File: rtl/crc.sv
// Ethernet CRC-32 engine, one byte per cycle, bits consumed LSB first.
// crc_out is the FCS in wire order: crc_out[31:24] is the first FCS byte.
module crc (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  data,
    input  logic        calc,
    output logic [31:0] crc_out
);

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    logic [31:0] crc_reg;
    logic [31:0] crc_next;

    // Non-reflected shift register fed with each data bit LSB first.
    always_comb begin
        crc_next = crc_reg;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[31] ^ data[i])
                crc_next = {crc_next[30:0], 1'b0} ^ CRC_POLY;
            else
                crc_next = {crc_next[30:0], 1'b0};
        end
    end

    // Running remainder; clear has priority over calc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            crc_reg <= 32'hFFFF_FFFF;
        else if (clear)
            crc_reg <= 32'hFFFF_FFFF;
        else if (calc)
            crc_reg <= crc_next;
    end

    // Complement and bit-reverse within each byte to obtain wire-order FCS.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_out
            assign crc_out[gi] = ~crc_reg[(gi / 8) * 8 + 7 - (gi % 8)];
        end
    endgenerate

endmodule

// File: rtl/ether_arp_rx.sv
// GMII receive ARP parser: strips preamble/SFD, checks FCS, length and
// ARP header fields, and strobes out sender MAC/IP/opcode for frames
// addressed to this station.
module ether_arp_rx
    import ether_pkg::*;
#(
    parameter logic [47:0] OWN_MAC_ADDR = 48'h00301ba0a48e,
    parameter logic [31:0] OWN_IP_ADDR  = {8'd172, 8'd16, 8'd0, 8'd230},
    parameter logic [11:0] MIN_FRAME    = 12'd64,
    parameter logic [11:0] MAX_FRAME    = 12'd1518
) (
    input  logic        clk_125,
    input  logic        rst,
    input  logic        phy_dv,
    input  logic        phy_er,
    input  logic [7:0]  phy_data,
    output logic        arp_valid,
    output logic [15:0] arp_opcode,
    output logic [47:0] arp_src_mac,
    output logic [31:0] arp_src_ip,
    output logic        rx_err,
    output logic [15:0] rx_good_cnt
);

    rx_state_t   state_reg;
    rx_state_t   state_next;

    logic [11:0] cnt_reg;
    logic        err_flag_reg;
    logic [7:0]  dly_reg [FCS_BYTES];

    logic [47:0] dst_reg;
    logic [15:0] type_reg;
    logic [15:0] htype_reg;
    logic [15:0] ptype_reg;
    logic [7:0]  hlen_reg;
    logic [7:0]  plen_reg;
    logic [15:0] op_reg;
    logic [47:0] sha_reg;
    logic [31:0] spa_reg;
    logic [31:0] tpa_reg;

    logic        arp_valid_reg;
    logic        rx_err_reg;
    logic [15:0] arp_opcode_reg;
    logic [47:0] arp_src_mac_reg;
    logic [31:0] arp_src_ip_reg;
    logic [15:0] rx_good_cnt_reg;

    logic        crc_clear;
    logic        crc_calc;
    logic        sfd_seen;
    logic        pre_err;
    logic        frame_end;
    logic        body_byte;
    logic [31:0] crc_out;
    logic [31:0] fcs_word;
    logic        crc_ok;
    logic        len_ok;
    logic        field_match;
    logic        frame_good;

    assign body_byte = (state_reg == ST_BODY) && phy_dv;

    // State register.
    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic plus per-cycle control pulses for the datapath.
    always_comb begin
        state_next = state_reg;
        crc_clear  = 1'b0;
        crc_calc   = 1'b0;
        sfd_seen   = 1'b0;
        pre_err    = 1'b0;
        frame_end  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (phy_dv)
                    state_next = (phy_data == PREAMBLE) ? ST_PRE : ST_DROP;
            end
            ST_PRE: begin
                if (!phy_dv) begin
                    state_next = ST_DROP;
                    pre_err    = 1'b1;
                end else if (phy_data == SFD) begin
                    state_next = ST_BODY;
                    crc_clear  = 1'b1;
                    sfd_seen   = 1'b1;
                end else if (phy_data != PREAMBLE) begin
                    state_next = ST_DROP;
                    pre_err    = 1'b1;
                end
            end
            ST_BODY: begin
                if (phy_dv) begin
                    // Only once the delay line is full does a byte fall out into the CRC.
                    crc_calc = (cnt_reg >= 12'(FCS_BYTES));
                end else begin
                    state_next = ST_CHECK;
                    frame_end  = 1'b1;
                end
            end
            ST_CHECK: begin
                // Zero inter-frame gap: the new frame lost its first byte, discard it.
                state_next = phy_dv ? ST_DROP : ST_IDLE;
            end
            ST_DROP: begin
                if (!phy_dv)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Byte counter (saturating) and sticky receive-error flag.
    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            err_flag_reg <= 1'b0;
        end else if (sfd_seen) begin
            cnt_reg      <= '0;
            err_flag_reg <= 1'b0;
        end else if (body_byte) begin
            if (cnt_reg != 12'hFFF)
                cnt_reg <= cnt_reg + 12'd1;
            if (phy_er)
                err_flag_reg <= 1'b1;
        end
    end

    // Delay line head: the newest body byte.
    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst)
            dly_reg[0] <= '0;
        else if (body_byte)
            dly_reg[0] <= phy_data;
    end

    // Remaining delay stages; the last stage feeds the CRC.
    genvar gi;
    generate
        for (gi = 1; gi < FCS_BYTES; gi++) begin : g_dly
            always_ff @(posedge clk_125 or posedge rst) begin
                if (rst)
                    dly_reg[gi] <= '0;
                else if (body_byte)
                    dly_reg[gi] <= dly_reg[gi-1];
            end
        end
    endgenerate

    // Header shadow registers, filled MSB-first as each field's bytes arrive.
    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            dst_reg   <= '0;
            type_reg  <= '0;
            htype_reg <= '0;
            ptype_reg <= '0;
            hlen_reg  <= '0;
            plen_reg  <= '0;
            op_reg    <= '0;
            sha_reg   <= '0;
            spa_reg   <= '0;
            tpa_reg   <= '0;
        end else if (body_byte) begin
            if (in_field(cnt_reg, OFF_DST, 12'd6))   dst_reg   <= {dst_reg[39:0], phy_data};
            if (in_field(cnt_reg, OFF_TYPE, 12'd2))  type_reg  <= {type_reg[7:0], phy_data};
            if (in_field(cnt_reg, OFF_HTYPE, 12'd2)) htype_reg <= {htype_reg[7:0], phy_data};
            if (in_field(cnt_reg, OFF_PTYPE, 12'd2)) ptype_reg <= {ptype_reg[7:0], phy_data};
            if (cnt_reg == OFF_HLEN)                 hlen_reg  <= phy_data;
            if (cnt_reg == OFF_PLEN)                 plen_reg  <= phy_data;
            if (in_field(cnt_reg, OFF_OP, 12'd2))    op_reg    <= {op_reg[7:0], phy_data};
            if (in_field(cnt_reg, OFF_SHA, 12'd6))   sha_reg   <= {sha_reg[39:0], phy_data};
            if (in_field(cnt_reg, OFF_SPA, 12'd4))   spa_reg   <= {spa_reg[23:0], phy_data};
            if (in_field(cnt_reg, OFF_TPA, 12'd4))   tpa_reg   <= {tpa_reg[23:0], phy_data};
        end
    end

    crc u_crc (
        .clk     (clk_125),
        .reset   (rst),
        .clear   (crc_clear),
        .data    (dly_reg[FCS_BYTES-1]),
        .calc    (crc_calc),
        .crc_out (crc_out)
    );

    // When the frame ends the delay line holds the FCS, oldest byte in the last stage.
    assign fcs_word    = {dly_reg[3], dly_reg[2], dly_reg[1], dly_reg[0]};
    assign crc_ok      = (crc_out == fcs_word);
    assign len_ok      = (cnt_reg >= MIN_FRAME) && (cnt_reg <= MAX_FRAME);
    assign frame_good  = crc_ok && !err_flag_reg && len_ok;
    assign field_match = ((dst_reg == 48'hFFFF_FFFF_FFFF) || (dst_reg == OWN_MAC_ADDR)) &&
                         (type_reg  == ETHERTYPE_ARP) &&
                         (htype_reg == ARP_HTYPE_ETH) &&
                         (ptype_reg == ETHERTYPE_IP) &&
                         (hlen_reg  == ARP_HLEN_ETH) &&
                         (plen_reg  == ARP_PLEN_IP) &&
                         ((op_reg == ARP_OP_REQ) || (op_reg == ARP_OP_REPLY)) &&
                         (tpa_reg   == OWN_IP_ADDR);

    // Result strobes, good-frame counter and held ARP outputs.
    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            arp_valid_reg   <= 1'b0;
            rx_err_reg      <= 1'b0;
            arp_opcode_reg  <= '0;
            arp_src_mac_reg <= '0;
            arp_src_ip_reg  <= '0;
            rx_good_cnt_reg <= '0;
        end else begin
            arp_valid_reg <= 1'b0;
            rx_err_reg    <= pre_err;
            if (frame_end) begin
                rx_err_reg    <= !frame_good;
                arp_valid_reg <= frame_good && field_match;
                if (frame_good)
                    rx_good_cnt_reg <= rx_good_cnt_reg + 16'd1;
                if (frame_good && field_match) begin
                    arp_opcode_reg  <= op_reg;
                    arp_src_mac_reg <= sha_reg;
                    arp_src_ip_reg  <= spa_reg;
                end
            end
        end
    end

    assign arp_valid   = arp_valid_reg;
    assign rx_err      = rx_err_reg;
    assign arp_opcode  = arp_opcode_reg;
    assign arp_src_mac = arp_src_mac_reg;
    assign arp_src_ip  = arp_src_ip_reg;
    assign rx_good_cnt = rx_good_cnt_reg;

endmodule

// File: tb/tb_ether_arp_rx.sv
// Directed testbench for ether_arp_rx: builds ARP frames with a reference
// FCS and checks strobes, held outputs and the good-frame counter.
module tb_ether_arp_rx;

    localparam logic [47:0] OWN_MAC = 48'h00301ba0a48e;
    localparam logic [31:0] OWN_IP  = 32'hac1000e6;
    localparam logic [47:0] BCAST   = 48'hffffffffffff;

    logic        clk_125  = 1'b0;
    logic        rst      = 1'b1;
    logic        phy_dv   = 1'b0;
    logic        phy_er   = 1'b0;
    logic [7:0]  phy_data = 8'h00;
    logic        arp_valid;
    logic [15:0] arp_opcode;
    logic [47:0] arp_src_mac;
    logic [31:0] arp_src_ip;
    logic        rx_err;
    logic [15:0] rx_good_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int valid_hi     = 0;
    int err_hi       = 0;

    logic [7:0] frm [0:127];
    int         frm_len = 0;
    logic       v_lat, e_lat, v_after;

    always #4 clk_125 = ~clk_125;

    ether_arp_rx #(
        .OWN_MAC_ADDR (OWN_MAC),
        .OWN_IP_ADDR  (OWN_IP),
        .MIN_FRAME    (12'd64),
        .MAX_FRAME    (12'd1518)
    ) dut (
        .clk_125     (clk_125),
        .rst         (rst),
        .phy_dv      (phy_dv),
        .phy_er      (phy_er),
        .phy_data    (phy_data),
        .arp_valid   (arp_valid),
        .arp_opcode  (arp_opcode),
        .arp_src_mac (arp_src_mac),
        .arp_src_ip  (arp_src_ip),
        .rx_err      (rx_err),
        .rx_good_cnt (rx_good_cnt)
    );

    // Count every cycle each strobe is high, to catch extra or stretched pulses.
    always @(negedge clk_125) begin
        if (arp_valid) valid_hi++;
        if (rx_err)    err_hi++;
    end

    // Reference Ethernet CRC-32, reflected form.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Build an ARP frame of plen bytes (dst..pad) followed by its FCS.
    task automatic build_arp(input logic [47:0] dst, input logic [15:0] op,
                             input logic [47:0] sha, input logic [31:0] spa,
                             input logic [31:0] tpa, input int plen);
        logic [31:0] c;
        for (int i = 0; i < plen; i++) frm[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            frm[i]      = dst[47-8*i -: 8];
            frm[6+i]    = sha[47-8*i -: 8];
            frm[22+i]   = sha[47-8*i -: 8];
        end
        frm[12] = 8'h08; frm[13] = 8'h06;
        frm[14] = 8'h00; frm[15] = 8'h01;
        frm[16] = 8'h08; frm[17] = 8'h00;
        frm[18] = 8'h06; frm[19] = 8'h04;
        frm[20] = op[15:8]; frm[21] = op[7:0];
        for (int i = 0; i < 4; i++) begin
            frm[28+i] = spa[31-8*i -: 8];
            frm[38+i] = tpa[31-8*i -: 8];
        end
        c = 32'hFFFFFFFF;
        for (int i = 0; i < plen; i++) c = crc_step(c, frm[i]);
        c = ~c;
        frm[plen]   = c[7:0];
        frm[plen+1] = c[15:8];
        frm[plen+2] = c[23:16];
        frm[plen+3] = c[31:24];
        frm_len = plen + 4;
    endtask

    // Send preamble, SFD and frm[], then sample strobes at the expected latency.
    task automatic send_frame(input int pre_bad, input int er_off, input int rst_off);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_125);
            phy_dv = 1'b1; phy_er = 1'b0;
            phy_data = (i == pre_bad) ? 8'h12 : 8'h55;
        end
        @(negedge clk_125);
        phy_data = 8'hD5;
        for (int i = 0; i < frm_len; i++) begin
            @(negedge clk_125);
            phy_data = frm[i];
            phy_er   = (i == er_off);
            rst      = (i == rst_off);
        end
        @(negedge clk_125);
        phy_dv = 1'b0; phy_er = 1'b0; phy_data = 8'h00; rst = 1'b0;
        @(negedge clk_125);
        v_lat = arp_valid; e_lat = rx_err;
        @(negedge clk_125);
        v_after = arp_valid;
        repeat (10) @(negedge clk_125);
        $display("[TB] frame len=%0d valid=%0b err=%0b good_cnt=%0d op=%h mac=%h ip=%h",
                 frm_len, v_lat, e_lat, rx_good_cnt, arp_opcode, arp_src_mac, arp_src_ip);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_125);
        tests_run++; if (arp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_arp_valid: got %b want 0", arp_valid); end
        tests_run++; if (rx_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_err: got %b want 0", rx_err); end
        tests_run++; if (arp_opcode !== 16'h0) begin tests_failed++; $display("FAIL reset_opcode: got %h want 0", arp_opcode); end
        tests_run++; if (arp_src_mac !== 48'h0) begin tests_failed++; $display("FAIL reset_mac: got %h want 0", arp_src_mac); end
        tests_run++; if (arp_src_ip !== 32'h0) begin tests_failed++; $display("FAIL reset_ip: got %h want 0", arp_src_ip); end
        tests_run++; if (rx_good_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_good_cnt: got %h want 0", rx_good_cnt); end
        rst = 1'b0;
        repeat (2) @(negedge clk_125);
    endtask

    task automatic test_arp_request();
        int v0, e0;
        v0 = valid_hi; e0 = err_hi;
        build_arp(BCAST, 16'h0001, 48'h001122334455, 32'hac100001, OWN_IP, 60);
        send_frame(-1, -1, -1);
        tests_run++; if (v_lat !== 1'b1) begin tests_failed++; $display("FAIL req_valid_latency: got %b want 1", v_lat); end
        tests_run++; if (v_after !== 1'b0) begin tests_failed++; $display("FAIL req_valid_width: got %b want 0", v_after); end
        tests_run++; if (valid_hi - v0 !== 1) begin tests_failed++; $display("FAIL req_valid_cycles: got %0d want 1", valid_hi - v0); end
        tests_run++; if (err_hi - e0 !== 0) begin tests_failed++; $display("FAIL req_err_cycles: got %0d want 0", err_hi - e0); end
        tests_run++; if (arp_opcode !== 16'h0001) begin tests_failed++; $display("FAIL req_opcode: got %h want 0001", arp_opcode); end
        tests_run++; if (arp_src_mac !== 48'h001122334455) begin tests_failed++; $display("FAIL req_mac: got %h want 001122334455", arp_src_mac); end
        tests_run++; if (arp_src_ip !== 32'hac100001) begin tests_failed++; $display("FAIL req_ip: got %h want ac100001", arp_src_ip); end
        tests_run++; if (rx_good_cnt !== 16'd1) begin tests_failed++; $display("FAIL req_good_cnt: got %0d want 1", rx_good_cnt); end
    endtask

    task automatic test_bad_fcs();
        int v0, e0;
        v0 = valid_hi; e0 = err_hi;
        build_arp(BCAST, 16'h0002, 48'h0a0b0c0d0e0f, 32'hac100005, OWN_IP, 60);
        frm[frm_len-1] = frm[frm_len-1] ^ 8'h01;
        send_frame(-1, -1, -1);
        tests_run++; if (e_lat !== 1'b1) begin tests_failed++; $display("FAIL badfcs_err: got %b want 1", e_lat); end
        tests_run++; if (valid_hi - v0 !== 0) begin tests_failed++; $display("FAIL badfcs_valid_cycles: got %0d want 0", valid_hi - v0); end
        tests_run++; if (err_hi - e0 !== 1) begin tests_failed++; $display("FAIL badfcs_err_cycles: got %0d want 1", err_hi - e0); end
        tests_run++; if (arp_opcode !== 16'h0001) begin tests_failed++; $display("FAIL badfcs_opcode_hold: got %h want 0001", arp_opcode); end
        tests_run++; if (arp_src_mac !== 48'h001122334455) begin tests_failed++; $display("FAIL badfcs_mac_hold: got %h want 001122334455", arp_src_mac); end
        tests_run++; if (arp_src_ip !== 32'hac100001) begin tests_failed++; $display("FAIL badfcs_ip_hold: got %h want ac100001", arp_src_ip); end
        tests_run++; if (rx_good_cnt !== 16'd1) begin tests_failed++; $display("FAIL badfcs_good_cnt: got %0d want 1", rx_good_cnt); end
    endtask

    task automatic test_reply_other_ip();
        int v0, e0;
        v0 = valid_hi; e0 = err_hi;
        build_arp(OWN_MAC, 16'h0002, 48'h0a0b0c0d0e0f, 32'hac100005, 32'hac100002, 60);
        send_frame(-1, -1, -1);
        tests_run++; if (valid_hi - v0 !== 0) begin tests_failed++; $display("FAIL other_ip_valid_cycles: got %0d want 0", valid_hi - v0); end
        tests_run++; if (err_hi - e0 !== 0) begin tests_failed++; $display("FAIL other_ip_err_cycles: got %0d want 0", err_hi - e0); end
        tests_run++; if (rx_good_cnt !== 16'd2) begin tests_failed++; $display("FAIL other_ip_good_cnt: got %0d want 2", rx_good_cnt); end
    endtask

    task automatic test_reply_unicast();
        build_arp(OWN_MAC, 16'h0002, 48'h665544332211, 32'hac100007, OWN_IP, 60);
        send_frame(-1, -1, -1);
        tests_run++; if (v_lat !== 1'b1) begin tests_failed++; $display("FAIL unicast_valid: got %b want 1", v_lat); end
        tests_run++; if (arp_opcode !== 16'h0002) begin tests_failed++; $display("FAIL unicast_opcode: got %h want 0002", arp_opcode); end
        tests_run++; if (arp_src_mac !== 48'h665544332211) begin tests_failed++; $display("FAIL unicast_mac: got %h want 665544332211", arp_src_mac); end
        tests_run++; if (arp_src_ip !== 32'hac100007) begin tests_failed++; $display("FAIL unicast_ip: got %h want ac100007", arp_src_ip); end
        tests_run++; if (rx_good_cnt !== 16'd3) begin tests_failed++; $display("FAIL unicast_good_cnt: got %0d want 3", rx_good_cnt); end
    endtask

    task automatic test_phy_er();
        int v0, e0;
        v0 = valid_hi; e0 = err_hi;
        build_arp(BCAST, 16'h0001, 48'h001122334455, 32'hac100001, OWN_IP, 60);
        send_frame(-1, 30, -1);
        tests_run++; if (e_lat !== 1'b1) begin tests_failed++; $display("FAIL phy_er_err: got %b want 1", e_lat); end
        tests_run++; if (valid_hi - v0 !== 0) begin tests_failed++; $display("FAIL phy_er_valid_cycles: got %0d want 0", valid_hi - v0); end
        tests_run++; if (err_hi - e0 !== 1) begin tests_failed++; $display("FAIL phy_er_err_cycles: got %0d want 1", err_hi - e0); end
        tests_run++; if (rx_good_cnt !== 16'd3) begin tests_failed++; $display("FAIL phy_er_good_cnt: got %0d want 3", rx_good_cnt); end
    endtask

    task automatic test_runt();
        int v0, e0;
        v0 = valid_hi; e0 = err_hi;
        build_arp(BCAST, 16'h0001, 48'h001122334455, 32'hac100001, OWN_IP, 56);
        send_frame(-1, -1, -1);
        tests_run++; if (e_lat !== 1'b1) begin tests_failed++; $display("FAIL runt_err: got %b want 1", e_lat); end
        tests_run++; if (valid_hi - v0 !== 0) begin tests_failed++; $display("FAIL runt_valid_cycles: got %0d want 0", valid_hi - v0); end
        tests_run++; if (err_hi - e0 !== 1) begin tests_failed++; $display("FAIL runt_err_cycles: got %0d want 1", err_hi - e0); end
        tests_run++; if (rx_good_cnt !== 16'd3) begin tests_failed++; $display("FAIL runt_good_cnt: got %0d want 3", rx_good_cnt); end
    endtask

    task automatic test_bad_preamble();
        int v0, e0;
        v0 = valid_hi; e0 = err_hi;
        build_arp(BCAST, 16'h0001, 48'h001122334455, 32'hac100001, OWN_IP, 60);
        send_frame(3, -1, -1);
        tests_run++; if (valid_hi - v0 !== 0) begin tests_failed++; $display("FAIL badpre_valid_cycles: got %0d want 0", valid_hi - v0); end
        tests_run++; if (err_hi - e0 !== 1) begin tests_failed++; $display("FAIL badpre_err_cycles: got %0d want 1", err_hi - e0); end
        tests_run++; if (rx_good_cnt !== 16'd3) begin tests_failed++; $display("FAIL badpre_good_cnt: got %0d want 3", rx_good_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0;
        v0 = valid_hi; e0 = err_hi;
        build_arp(BCAST, 16'h0001, 48'h001122334455, 32'hac100001, OWN_IP, 60);
        send_frame(-1, -1, 20);
        tests_run++; if (valid_hi - v0 !== 0) begin tests_failed++; $display("FAIL midrst_valid_cycles: got %0d want 0", valid_hi - v0); end
        tests_run++; if (err_hi - e0 !== 0) begin tests_failed++; $display("FAIL midrst_err_cycles: got %0d want 0", err_hi - e0); end
        tests_run++; if (rx_good_cnt !== 16'd0) begin tests_failed++; $display("FAIL midrst_good_cnt: got %0d want 0", rx_good_cnt); end
        tests_run++; if (arp_opcode !== 16'h0) begin tests_failed++; $display("FAIL midrst_opcode: got %h want 0", arp_opcode); end
        build_arp(BCAST, 16'h0001, 48'h0000aabbccdd, 32'hac100009, OWN_IP, 60);
        send_frame(-1, -1, -1);
        tests_run++; if (v_lat !== 1'b1) begin tests_failed++; $display("FAIL midrst_next_valid: got %b want 1", v_lat); end
        tests_run++; if (arp_src_mac !== 48'h0000aabbccdd) begin tests_failed++; $display("FAIL midrst_next_mac: got %h want 0000aabbccdd", arp_src_mac); end
        tests_run++; if (rx_good_cnt !== 16'd1) begin tests_failed++; $display("FAIL midrst_next_good_cnt: got %0d want 1", rx_good_cnt); end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_hi;
        build_arp(BCAST, 16'h0001, 48'h0200000000a1, 32'hac100011, OWN_IP, 60);
        send_frame(-1, -1, -1);
        tests_run++; if (v_lat !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_valid: got %b want 1", v_lat); end
        build_arp(OWN_MAC, 16'h0002, 48'h0200000000b2, 32'hac100022, OWN_IP, 60);
        send_frame(-1, -1, -1);
        tests_run++; if (v_lat !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_valid: got %b want 1", v_lat); end
        tests_run++; if (valid_hi - v0 !== 2) begin tests_failed++; $display("FAIL b2b_valid_cycles: got %0d want 2", valid_hi - v0); end
        tests_run++; if (arp_src_ip !== 32'hac100022) begin tests_failed++; $display("FAIL b2b_ip: got %h want ac100022", arp_src_ip); end
        tests_run++; if (rx_good_cnt !== 16'd3) begin tests_failed++; $display("FAIL b2b_good_cnt: got %0d want 3", rx_good_cnt); end
    endtask

    task automatic test_count_wrap();
        @(negedge clk_125);
        force dut.rx_good_cnt_reg = 16'hFFFE;
        @(negedge clk_125);
        release dut.rx_good_cnt_reg;
        @(negedge clk_125);
        build_arp(BCAST, 16'h0001, 48'h001122334455, 32'hac100001, OWN_IP, 60);
        send_frame(-1, -1, -1);
        tests_run++; if (rx_good_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_ffff: got %h want ffff", rx_good_cnt); end
        send_frame(-1, -1, -1);
        tests_run++; if (rx_good_cnt !== 16'h0000) begin tests_failed++; $display("FAIL wrap_zero: got %h want 0000", rx_good_cnt); end
        tests_run++; if (v_lat !== 1'b1) begin tests_failed++; $display("FAIL wrap_valid: got %b want 1", v_lat); end
    endtask

    initial begin
        test_reset();
        test_arp_request();
        test_bad_fcs();
        test_reply_other_ip();
        test_reply_unicast();
        test_phy_er();
        test_runt();
        test_bad_preamble();
        test_reset_mid_frame();
        test_back_to_back();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
